// File: rtl/fetch_stage_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage_ctrl_pkg : shared types and constants for the fetch stage
// Revision: 1.0
// ---------------------------------------------------------------------------
package fetch_stage_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_HELD  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;
   localparam int          PC_INC   = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage_ctrl_if : instruction-memory request/response bus
// Revision: 1.0
// ---------------------------------------------------------------------------
interface fetch_stage_ctrl_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_hold_buf : one-entry {pc, instr} buffer, clear wins over load
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_hold_buf #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   output logic            full,
   output logic [XLEN-1:0] buf_pc,
   output logic [31:0]     buf_instr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full      <= 1'b0;
         buf_pc    <= '0;
         buf_instr <= '0;
      end else if (clear) begin
         full      <= 1'b0;
      end else if (load) begin
         full      <= 1'b1;
         buf_pc    <= in_pc;
         buf_instr <= in_instr;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_stage_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage_ctrl : PC / IF-ID owner with stall, branch flush and hold buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_stage_ctrl
   import fetch_stage_ctrl_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = NOP_WORD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             PC_Write,
   input  logic             IF_ID_Write,
   input  logic             branch_taken,
   input  logic [XLEN-1:0]  branch_target,
   fetch_stage_ctrl_if.master imem,
   output logic [XLEN-1:0]  IF_ID_pc,
   output logic [31:0]      IF_ID_instr,
   output logic             IF_ID_valid
);

   fetch_state_t    state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic [XLEN-1:0] drain_addr, drain_addr_n;
   logic [XLEN-1:0] ifid_pc_n;
   logic [31:0]     ifid_instr_n;
   logic            ifid_valid_n;
   logic            buf_load, buf_clear, buf_full;
   logic [XLEN-1:0] buf_pc;
   logic [31:0]     buf_instr;
   logic            advance;
   logic [XLEN-1:0] pc_inc;

   assign advance = PC_Write && IF_ID_Write;
   assign pc_inc  = pc + XLEN'(PC_INC);

   assign imem.imem_req  = rst_n && (state != ST_HELD);
   assign imem.imem_addr = (state == ST_DRAIN) ? drain_addr : pc;

   fetch_hold_buf #(.XLEN(XLEN)) u_hold_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (buf_load),
      .clear     (buf_clear),
      .in_pc     (pc),
      .in_instr  (imem.imem_rdata),
      .full      (buf_full),
      .buf_pc    (buf_pc),
      .buf_instr (buf_instr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_REQ;
         pc          <= RESET_PC;
         drain_addr  <= '0;
         IF_ID_pc    <= '0;
         IF_ID_instr <= NOP_INSTR;
         IF_ID_valid <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         drain_addr  <= drain_addr_n;
         IF_ID_pc    <= ifid_pc_n;
         IF_ID_instr <= ifid_instr_n;
         IF_ID_valid <= ifid_valid_n;
      end
   end

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      drain_addr_n = drain_addr;
      ifid_pc_n    = IF_ID_pc;
      ifid_instr_n = IF_ID_instr;
      ifid_valid_n = IF_ID_valid;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;

      if (branch_taken) begin
         // Redirect beats any stall; an outstanding request must still drain.
         pc_n         = {branch_target[XLEN-1:2], 2'b00};
         ifid_pc_n    = pc;
         ifid_instr_n = NOP_INSTR;
         ifid_valid_n = 1'b0;
         buf_clear    = 1'b1;
         case (state)
            ST_REQ: begin
               if (!imem.imem_ready) begin
                  drain_addr_n = pc;
                  state_n      = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (imem.imem_ready) state_n = ST_REQ;
            end
            default: state_n = ST_REQ;
         endcase
      end else begin
         case (state)
            ST_REQ: begin
               if (imem.imem_ready && advance) begin
                  ifid_pc_n    = pc;
                  ifid_instr_n = imem.imem_rdata;
                  ifid_valid_n = 1'b1;
                  pc_n         = pc_inc;
               end else if (imem.imem_ready) begin
                  buf_load = 1'b1;
                  state_n  = ST_HELD;
               end else if (advance) begin
                  ifid_pc_n    = pc;
                  ifid_instr_n = NOP_INSTR;
                  ifid_valid_n = 1'b0;
               end
            end
            ST_HELD: begin
               if (advance && buf_full) begin
                  ifid_pc_n    = buf_pc;
                  ifid_instr_n = buf_instr;
                  ifid_valid_n = 1'b1;
                  pc_n         = pc_inc;
                  buf_clear    = 1'b1;
                  state_n      = ST_REQ;
               end
            end
            ST_DRAIN: begin
               if (imem.imem_ready) state_n = ST_REQ;
            end
            default: state_n = ST_REQ;
         endcase
      end
   end

endmodule
`default_nettype wire
